// File: rtl/mem_bus_arbiter_if.sv
// Fetch/data request, response and memory bus bundle for mem_bus_arbiter.
// master: arbiter side (drives responses and bus); slave: everything else.
interface mem_bus_arbiter_if;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_ready;
  logic [31:0] iresp_data;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic        dreq_write;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_ready;
  logic [63:0] dresp_data;
  logic        bus_valid;
  logic        bus_write;
  logic [63:0] bus_addr;
  logic [2:0]  bus_size;
  logic [7:0]  bus_strobe;
  logic [63:0] bus_wdata;
  logic        bus_ready;
  logic [63:0] bus_rdata;

  modport master (
    input  ireq_valid, ireq_addr,
    input  dreq_valid, dreq_addr, dreq_write,
    input  dreq_size, dreq_strobe, dreq_data,
    input  bus_ready, bus_rdata,
    output iresp_ready, iresp_data,
    output dresp_ready, dresp_data,
    output bus_valid, bus_write, bus_addr,
    output bus_size, bus_strobe, bus_wdata
  );

  modport slave (
    output ireq_valid, ireq_addr,
    output dreq_valid, dreq_addr, dreq_write,
    output dreq_size, dreq_strobe, dreq_data,
    output bus_ready, bus_rdata,
    input  iresp_ready, iresp_data,
    input  dresp_ready, dresp_data,
    input  bus_valid, bus_write, bus_addr,
    input  bus_size, bus_strobe, bus_wdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between fetch and data ports; D wins unless fetch starved.
// Ports: clk, reset (async, active-low), io (mem_bus_arbiter_if.master).
module mem_bus_arbiter #(
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  mem_bus_arbiter_if.master io
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;
  localparam logic [1:0] DRAIN  = 2'd3;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

  logic [1:0]  state;
  logic [3:0]  streak;
  logic        b_valid;
  logic        b_write;
  logic [63:0] b_addr;
  logic [2:0]  b_size;
  logic [7:0]  b_strobe;
  logic [63:0] b_wdata;

  logic forced_i;
  logic grant_d;
  logic grant_i;

  always_comb begin
    forced_i = io.ireq_valid && (streak == STREAK_MAX);
    grant_d  = (state == IDLE) && io.dreq_valid && !forced_i;
    grant_i  = (state == IDLE) && !grant_d && io.ireq_valid;
  end

  assign io.bus_valid  = b_valid;
  assign io.bus_write  = b_write;
  assign io.bus_addr   = b_addr;
  assign io.bus_size   = b_size;
  assign io.bus_strobe = b_strobe;
  assign io.bus_wdata  = b_wdata;

  // A fetch whose valid drops in the completing cycle is a flush:
  // the response is discarded.
  always_comb begin
    io.iresp_ready = 1'b0;
    io.iresp_data  = '0;
    io.dresp_ready = 1'b0;
    io.dresp_data  = '0;
    if (state == BUSY_I && io.bus_ready && io.ireq_valid) begin
      io.iresp_ready = 1'b1;
      io.iresp_data  = b_addr[2] ? io.bus_rdata[63:32]
                                 : io.bus_rdata[31:0];
    end
    if (state == BUSY_D && io.bus_ready) begin
      io.dresp_ready = 1'b1;
      io.dresp_data  = io.bus_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      streak   <= '0;
      b_valid  <= 1'b0;
      b_write  <= 1'b0;
      b_addr   <= '0;
      b_size   <= '0;
      b_strobe <= '0;
      b_wdata  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_d) begin
            state    <= BUSY_D;
            b_valid  <= 1'b1;
            b_write  <= io.dreq_write;
            b_addr   <= io.dreq_addr;
            b_size   <= io.dreq_size;
            b_strobe <= io.dreq_write ? io.dreq_strobe : 8'h00;
            b_wdata  <= io.dreq_data;
            if (!io.ireq_valid)
              streak <= '0;
            else if (streak != STREAK_MAX)
              streak <= streak + 4'd1;
          end else if (grant_i) begin
            state    <= BUSY_I;
            streak   <= '0;
            b_valid  <= 1'b1;
            b_write  <= 1'b0;
            b_addr   <= io.ireq_addr;
            b_size   <= 3'd2;
            b_strobe <= 8'h00;
            b_wdata  <= '0;
          end else begin
            streak <= '0;
          end
        end
        BUSY_I, BUSY_D, DRAIN: begin
          if (io.bus_ready) begin
            state    <= IDLE;
            b_valid  <= 1'b0;
            b_write  <= 1'b0;
            b_addr   <= '0;
            b_size   <= '0;
            b_strobe <= '0;
            b_wdata  <= '0;
          end else if (state == BUSY_I && !io.ireq_valid) begin
            // Flushed fetch: keep the bus request up until it lands.
            state <= DRAIN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single core memory bus between the instruction-fetch port and the data-memory port of the 5-stage pipeline.
- Registers the winning request onto the bus and holds it until the bus completes.
- Routes the response back to the requester.
- Sits between the fetch/memory stages and the bus; owns the fetch-flush drain protocol.

Parameters:
MAX_D_STREAK, 4, consecutive data grants allowed while a fetch waits before fetch is forced (1..15)

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-low reset
ireq_valid  in  1  fetch request; level; may drop early only on flush
ireq_addr  in  64  fetch PC
iresp_ready  out  1  one-cycle pulse: fetch complete, iresp_data valid
iresp_data  out  32  fetched instruction
dreq_valid  in  1  data request; level; must hold until dresp_ready
dreq_addr  in  64  data address
dreq_write  in  1  1 = store
dreq_size  in  3  log2 bytes (0..3)
dreq_strobe  in  8  byte enables (store)
dreq_data  in  64  store data
dresp_ready  out  1  one-cycle pulse: data access complete
dresp_data  out  64  load data
bus_valid  out  1  bus request
bus_write  out  1  1 = store
bus_addr  out  64  address
bus_size  out  3  size
bus_strobe  out  8  byte enables (0 for reads)
bus_wdata  out  64  store data
bus_ready  in  1  one-cycle completion pulse
bus_rdata  in  64  read data

Behaviour:
- States: IDLE, BUSY_I, BUSY_D, DRAIN. Reset: IDLE, all outputs 0, streak counter 0. Reset is async; a bus transaction in flight is abandoned and bus_valid drops immediately.
- IDLE, arbitration each cycle:
  - dreq_valid and not forced-I -> BUSY_D.
  - else ireq_valid -> BUSY_I.
  - forced-I = ireq_valid and streak == MAX_D_STREAK.
- On grant, latch all request fields into bus output registers. bus_valid asserts the cycle after the request is seen in IDLE.
- Fetch bus fields: bus_write=0, bus_size=2, bus_strobe=0, bus_wdata=0.
- Bus outputs are stable while bus_valid=1 until bus_ready. Requester inputs are not re-sampled.
- BUSY_I, bus_ready=1:
  - iresp_ready=1 same cycle.
  - iresp_data = bus_rdata[31:0] if latched addr[2]=0, else bus_rdata[63:32].
  - bus_valid drops next cycle; return to IDLE.
- BUSY_I, ireq_valid=0 before bus_ready (flush) -> DRAIN.
  - A new ireq_valid in the same or later cycle is not granted until DRAIN ends.
- DRAIN: bus_valid held. On bus_ready go to IDLE with no iresp_ready pulse and the response discarded.
- BUSY_D, bus_ready=1: dresp_ready=1, dresp_data=bus_rdata same cycle, then IDLE.
  - dreq_valid dropping in BUSY_D is a protocol violation. The block still completes and pulses dresp_ready; the bench flags it with an assertion.
- Throughput: one IDLE bubble between transactions. Minimum 3 cycles per access for a bus with 1-cycle ready.
- Streak counter (4 bits):
  - +1 on a D grant while ireq_valid=1, saturating at MAX_D_STREAK.
  - Cleared on any I grant, or in IDLE when ireq_valid=0.
- Response outputs are 0 whenever not pulsing.
- bus_ready while in IDLE is ignored.

Test Plan:
- Fetch only: ireq_valid, ireq_addr=0x8000_0004, bus_ready 2 cycles after bus_valid with rdata=0x00A0_0093_0000_0013 -> bus_addr=0x8000_0004, size=2; iresp_ready one pulse, iresp_data=0x00A0_0093.
- Store only: dreq addr=0x8000_1000, size=3, strobe=0xFF, data=0x1234 -> bus_write=1, fields held stable over 3 wait cycles; one dresp_ready pulse.
- Simultaneous I and D in IDLE -> D granted first; I granted in the IDLE after dresp_ready.
- Starvation, MAX_D_STREAK=2: ireq held, dreq continuously re-asserted -> D, D, I, then D; counter cleared after the I grant.
- Flush: ireq_valid drops 1 cycle into BUSY_I, new ireq at 0x8000_0100 asserted -> no iresp_ready for the old fetch. The new fetch reaches the bus only after the old bus_ready.
- Reset mid BUSY_D: assert reset before bus_ready -> bus_valid=0 and outputs 0 asynchronously, no dresp_ready pulse; after release, a fresh fetch completes normally.
